fifo_flush_gray: RTL and testbench
==================================

# fifo_flush_gray

Single-clock 8-entry × 4-bit FIFO whose read and write pointers are held in Gray code, with a one-cycle flush that drains the entire contents onto a 32-bit packed output. It sits between a nibble-wide producer and a word-wide consumer that normally takes data in bulk via flush, and occasionally pops single entries. It reports occupancy, full and empty status.

## Interface
- DATA_W, 4, width of one entry
- ADDR_W, 3, log2 depth (depth 8)
- OUT_W, DATA_W << ADDR_W = 32, packed flush/read output width
- One clock; reset is asynchronous and active-high.
- clock  input  1  rising-edge clock for all state
- reset  input  1  asynchronous, active-high; clears all state
- fifo_wr_valid_i  input  1  write request for this cycle
- fifo_rd_valid_i  input  1  single-entry pop request
- fifo_flush_i  input  1  drain all entries onto fifo_rd_data_o
- fifo_wr_data_i  input  DATA_W  write data
- fifo_empty_o  output  1  occupancy == 0
- fifo_full_o  output  1  occupancy == 8
- fifo_rd_data_o  output  OUT_W  registered read/flush data
- fifo_curr_o  output  ADDR_W+1  current occupancy, 0..8

## Operation
- Pointers wr_ptr/rd_ptr: ADDR_W+1 bits, stored Gray; binary form used for addressing (low ADDR_W bits) and count.
- Count = bin(wr_ptr) − bin(rd_ptr), modulo 2^(ADDR_W+1).
- Empty: Gray pointers equal. Full: Gray pointers differ only in the top two bits (the standard Gray full test).
- Write: if fifo_wr_valid_i and not full, mem[wr_addr] <= data, wr_ptr advances. Write while full is dropped, including when a read or flush occurs in the same cycle.
- Pop: if fifo_rd_valid_i, no flush, and not empty:
  - fifo_rd_data_o <= zero-extended mem[rd_addr]
  - rd_ptr advances
  - Pop while empty is ignored; fifo_rd_data_o holds.
- Flush: if fifo_flush_i, fifo_rd_data_o <= packed contents.
  - Oldest entry in bits [3:0], next in [7:4], and so on.
  - Slots beyond occupancy are zero.
  - rd_ptr <= wr_ptr (pre-write value), so the FIFO becomes empty.
  - Flush on an empty FIFO outputs 0.
- Priority: flush over pop. A write in the same cycle as a flush or pop is accepted (if not full beforehand) and remains in the FIFO afterwards. It is never part of that cycle's output.
- Pointer wrap is natural modulo 2^(ADDR_W+1); no special handling.

## Timing
- All outputs registered; flags/count reflect state after the last clock edge.
- Write visible in count/empty one cycle after the accepting edge.
- Pop/flush data valid the cycle after the request edge; held until the next successful pop/flush.
- Reset values: pointers 0, fifo_rd_data_o 0, fifo_curr_o 0, fifo_empty_o 1, fifo_full_o 0. Memory need not be cleared.
- Reset mid-operation discards all contents immediately (asynchronous).

## Structure
- Package fifo_flush_pkg:
  - DATA_W / ADDR_W / OUT_W constants
  - bin2gray and gray2bin functions
- Sub-module fifo_gray_ptr: Gray-coded ADDR_W+1 pointer register with increment and load inputs. It outputs Gray and binary forms and is instantiated twice (write and read).
- Top holds the memory array, flag/count logic, and flush packing mux.

## Test plan
- Reset: assert reset → empty=1, full=0, curr=0, rd_data=0; release, no activity → unchanged.
- Write A,3,5 on consecutive cycles → curr 1,2,3; then flush → rd_data=0x0000053A, curr=0, empty=1.
- Write D,1, idle, flush → rd_data=0x0000001D. Second flush with no new writes → rd_data=0, empty remains 1.
- Write 8 entries 0..7 → full=1, curr=8; 9th write (F) ignored; flush → 0x76543210.
- Pop order: write A,3; pop → rd_data=0x0000000A, curr=1; pop → 0x3; pop on empty → rd_data stays 0x3. Simultaneous flush+pop → flush wins.
- Wrap and concurrency: 20 write/pop cycles crossing pointer wrap → data order preserved. Write B concurrent with flush of {5} → output 0x5, afterwards curr=1. Reset asserted mid-stream → immediate empty.

Source files
------------

// File: rtl/fifo_flush_pkg.sv
// Shared sizing constants and Gray/binary conversion helpers for fifo_flush_gray.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package fifo_flush_pkg;

  localparam int DATA_W = 4;                 // width of one entry
  localparam int ADDR_W = 3;                 // log2 of depth
  localparam int DEPTH  = 1 << ADDR_W;       // 8 entries
  localparam int OUT_W  = DATA_W << ADDR_W;  // whole-FIFO packed width (32)
  localparam int PTR_W  = ADDR_W + 1;        // extra MSB separates full from empty

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray_ptr.sv
// Gray-coded FIFO pointer register with increment and parallel load.
// Latency: new value visible one cycle after inc/load; load has priority over inc.
// Backpressure: none; caller qualifies inc/load with full/empty.
// Ports: clock, reset (async, active-high), inc, load, load_val (Gray),
//        gray (registered Gray value), bin (binary decode of gray).
module fifo_gray_ptr
  import fifo_flush_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             load,
  input  logic [PTR_W-1:0] load_val,
  output logic [PTR_W-1:0] gray,
  output logic [PTR_W-1:0] bin
);

  logic [PTR_W-1:0] gray_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gray_q <= '0;
    end else if (load) begin
      gray_q <= load_val;
    end else if (inc) begin
      // Increment in binary and re-encode; wrap is natural modulo 2^PTR_W.
      gray_q <= bin2gray(gray2bin(gray_q) + 1'b1);
    end
  end

  assign gray = gray_q;
  assign bin  = gray2bin(gray_q);

endmodule

// File: rtl/fifo_flush_gray.sv
// 8x4 FIFO with Gray pointers, single-entry pop and one-cycle flush of all entries to 32 bits.
// Latency: write visible in status next cycle; pop/flush data registered, valid next cycle.
// Backpressure: writes dropped while full; pops ignored while empty; flush beats pop.
// Ports: clock, reset (async, active-high); fifo_wr_valid_i/fifo_wr_data_i write side;
//        fifo_rd_valid_i pop, fifo_flush_i drain; fifo_rd_data_o registered output word;
//        fifo_empty_o, fifo_full_o, fifo_curr_o occupancy status.
module fifo_flush_gray
  import fifo_flush_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              fifo_wr_valid_i,
  input  logic              fifo_rd_valid_i,
  input  logic              fifo_flush_i,
  input  logic [DATA_W-1:0] fifo_wr_data_i,
  output logic              fifo_empty_o,
  output logic              fifo_full_o,
  output logic [OUT_W-1:0]  fifo_rd_data_o,
  output logic [ADDR_W:0]   fifo_curr_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wr_gray, wr_bin;
  logic [PTR_W-1:0]  rd_gray, rd_bin;
  logic [PTR_W-1:0]  count;
  logic              empty, full;
  logic              wr_en, pop_en;
  logic [OUT_W-1:0]  flush_word;
  logic [ADDR_W-1:0] slot;
  logic [OUT_W-1:0]  rd_data_q;

  assign count = wr_bin - rd_bin;
  assign empty = (wr_gray == rd_gray);
  // In Gray code, pointers one lap apart differ in exactly the top two bits.
  assign full  = ((wr_gray ^ rd_gray) == {2'b11, {(PTR_W-2){1'b0}}});

  assign wr_en  = fifo_wr_valid_i && !full;
  assign pop_en = fifo_rd_valid_i && !fifo_flush_i && !empty;

  fifo_gray_ptr u_wr_ptr (
    .clock    (clock),
    .reset    (reset),
    .inc      (wr_en),
    .load     (1'b0),
    .load_val ({PTR_W{1'b0}}),
    .gray     (wr_gray),
    .bin      (wr_bin)
  );

  // Flush snaps the read pointer to the pre-write write pointer, so a write
  // accepted in the same cycle survives as the sole entry.
  fifo_gray_ptr u_rd_ptr (
    .clock    (clock),
    .reset    (reset),
    .inc      (pop_en),
    .load     (fifo_flush_i),
    .load_val (wr_gray),
    .gray     (rd_gray),
    .bin      (rd_bin)
  );

  // Storage is not reset; occupancy gates every read so stale contents never leak.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_bin[ADDR_W-1:0]] <= fifo_wr_data_i;
    end
  end

  // Oldest entry lands in the low nibble; slots past the occupancy stay zero.
  always_comb begin
    flush_word = '0;
    slot       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_bin[ADDR_W-1:0] + ADDR_W'(i);
      if (PTR_W'(i) < count) begin
        flush_word[i*DATA_W +: DATA_W] = mem[slot];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (fifo_flush_i) begin
      rd_data_q <= flush_word;
    end else if (pop_en) begin
      rd_data_q <= {{(OUT_W-DATA_W){1'b0}}, mem[rd_bin[ADDR_W-1:0]]};
    end
  end

  assign fifo_rd_data_o = rd_data_q;
  assign fifo_empty_o   = empty;
  assign fifo_full_o    = full;
  assign fifo_curr_o    = count;

endmodule

// File: tb/tb_fifo_flush_gray.sv
// Directed self-checking bench for fifo_flush_gray.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 1ns after the next edge.
// Backpressure: exercises full-drop, empty-pop and flush-over-pop cases.
module tb_fifo_flush_gray;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic        rd_valid = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  wr_data = 4'h0;
  logic        empty;
  logic        full;
  logic [31:0] rd_data;
  logic [3:0]  curr;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  fifo_flush_gray dut (
    .clock           (clock),
    .reset           (reset),
    .fifo_wr_valid_i (wr_valid),
    .fifo_rd_valid_i (rd_valid),
    .fifo_flush_i    (flush),
    .fifo_wr_data_i  (wr_data),
    .fifo_empty_o    (empty),
    .fifo_full_o     (full),
    .fifo_rd_data_o  (rd_data),
    .fifo_curr_o     (curr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    flush    = 1'b0;
  endtask

  logic [3:0] v_prev;
  logic [3:0] v_cur;

  initial begin
    // Reset state while reset is held.
    #2;
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_curr", {28'd0, curr}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    step();
    reset = 1'b0;
    step();
    step();
    check("idle_empty", {31'd0, empty}, 32'd1);
    check("idle_curr", {28'd0, curr}, 32'd0);

    // Write A,3,5 then flush.
    wr_valid = 1'b1; wr_data = 4'hA; step();
    check("w1_curr", {28'd0, curr}, 32'd1);
    wr_data = 4'h3; step();
    check("w2_curr", {28'd0, curr}, 32'd2);
    wr_data = 4'h5; step();
    check("w3_curr", {28'd0, curr}, 32'd3);
    check("w3_empty", {31'd0, empty}, 32'd0);
    idle_inputs(); flush = 1'b1; step(); idle_inputs();
    check("fl1_data", rd_data, 32'h0000053A);
    check("fl1_curr", {28'd0, curr}, 32'd0);
    check("fl1_empty", {31'd0, empty}, 32'd1);

    // Write D,1, idle, flush; then flush again on empty.
    wr_valid = 1'b1; wr_data = 4'hD; step();
    wr_data = 4'h1; step();
    idle_inputs(); step();
    flush = 1'b1; step(); idle_inputs();
    check("fl2_data", rd_data, 32'h0000001D);
    flush = 1'b1; step(); idle_inputs();
    check("fl_empty_data", rd_data, 32'h00000000);
    check("fl_empty_empty", {31'd0, empty}, 32'd1);

    // Fill to 8, drop a 9th write, flush.
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_data = 4'(i); step();
    end
    idle_inputs();
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_curr", {28'd0, curr}, 32'd8);
    wr_valid = 1'b1; wr_data = 4'hF; step(); idle_inputs();
    check("drop_curr", {28'd0, curr}, 32'd8);
    check("drop_full", {31'd0, full}, 32'd1);
    flush = 1'b1; step(); idle_inputs();
    check("fl_full_data", rd_data, 32'h76543210);
    check("fl_full_empty", {31'd0, empty}, 32'd1);
    check("fl_full_nfull", {31'd0, full}, 32'd0);

    // Pop order, pop on empty, flush beats pop.
    wr_valid = 1'b1; wr_data = 4'hA; step();
    wr_data = 4'h3; step(); idle_inputs();
    rd_valid = 1'b1; step(); idle_inputs();
    check("pop1_data", rd_data, 32'h0000000A);
    check("pop1_curr", {28'd0, curr}, 32'd1);
    rd_valid = 1'b1; step(); idle_inputs();
    check("pop2_data", rd_data, 32'h00000003);
    check("pop2_empty", {31'd0, empty}, 32'd1);
    rd_valid = 1'b1; step(); idle_inputs();
    check("pop_empty_hold", rd_data, 32'h00000003);
    check("pop_empty_curr", {28'd0, curr}, 32'd0);
    wr_valid = 1'b1; wr_data = 4'h7; step();
    wr_data = 4'h9; step(); idle_inputs();
    flush = 1'b1; rd_valid = 1'b1; step(); idle_inputs();
    check("flpop_data", rd_data, 32'h00000097);
    check("flpop_empty", {31'd0, empty}, 32'd1);

    // 20 concurrent write/pop cycles crossing pointer wrap; one entry in flight.
    v_prev = 4'h5;
    wr_valid = 1'b1; wr_data = v_prev; step();
    for (int k = 1; k <= 20; k++) begin
      v_cur    = 4'(k * 7 + 3);
      wr_valid = 1'b1; wr_data = v_cur; rd_valid = 1'b1;
      step();
      check($sformatf("wrap_pop%0d", k), rd_data, {28'd0, v_prev});
      v_prev = v_cur;
    end
    idle_inputs();
    check("wrap_curr", {28'd0, curr}, 32'd1);
    flush = 1'b1; step(); idle_inputs();
    check("wrap_flush", rd_data, {28'd0, v_prev});

    // Write B concurrent with flush of {5}.
    wr_valid = 1'b1; wr_data = 4'h5; step();
    wr_data = 4'hB; flush = 1'b1; step(); idle_inputs();
    check("wfl_data", rd_data, 32'h00000005);
    check("wfl_curr", {28'd0, curr}, 32'd1);
    flush = 1'b1; step(); idle_inputs();
    check("wfl_after", rd_data, 32'h0000000B);

    // Asynchronous reset mid-stream clears state before any clock edge.
    wr_valid = 1'b1; wr_data = 4'h2; step();
    wr_data = 4'h4; step();
    wr_data = 4'h6; #2;
    reset = 1'b1; #1;
    check("arst_empty", {31'd0, empty}, 32'd1);
    check("arst_curr", {28'd0, curr}, 32'd0);
    check("arst_rd_data", rd_data, 32'd0);
    idle_inputs();
    step();
    reset = 1'b0;
    step();
    check("arst_hold_empty", {31'd0, empty}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
